// File: rtl/infer_perf_monitor_if.sv
// Snooped data-memory bus seen by infer_perf_monitor. A transfer is an edge with
// req, write and ready all high; the monitor side only ever observes these signals.
interface infer_perf_monitor_if #(
  parameter int DWidth = 32
);
  logic              req;
  logic              write;
  logic              ready;
  logic [DWidth-1:0] addr;
  logic [DWidth-1:0] wdata;

  // master: the real bus participants (core request, memory ready); slave: the snooper
  modport master (output req, write, ready, addr, wdata);
  modport slave  (input  req, write, ready, addr, wdata);
endinterface

// File: rtl/infer_perf_monitor.sv
// Inference-run monitor: snoops dmem writes to a 4-word MMIO window and keeps
// run state, image/correct counts, cycle/instret counts, latency min/max and a watchdog.
module infer_perf_monitor #(
  parameter int                DWidth        = 32,
  parameter logic [DWidth-1:0] MonBase       = 32'h0200_0000,
  parameter int                NumOfTest     = 100,
  parameter int                CntW          = 16,
  parameter int                ImgCycW       = 32,
  parameter logic [31:0]       TimeoutCycles = 32'h00FF_FFFF,
  parameter int                AccThreshPct  = 90,
  parameter logic [DWidth-1:0] ExitMagic     = 32'd99999
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  infer_perf_monitor_if.slave  dmem,
  input  logic                 retire_i,
  output logic [1:0]           state_o,
  output logic [CntW-1:0]      img_cnt_o,
  output logic [CntW-1:0]      correct_cnt_o,
  output logic [63:0]          cycle_cnt_o,
  output logic [63:0]          instret_cnt_o,
  output logic [ImgCycW-1:0]   min_img_cyc_o,
  output logic [ImgCycW-1:0]   max_img_cyc_o,
  output logic                 overflow_o,
  output logic                 pass_o
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StRun     = 2'd1;
  localparam logic [1:0] StDone    = 2'd2;
  localparam logic [1:0] StTimeout = 2'd3;

  localparam int                 AW         = DWidth - 2;
  localparam logic [AW-1:0]      CtrlWord   = MonBase[DWidth-1:2];
  localparam logic [AW-1:0]      ImgWord    = CtrlWord + AW'(1);
  localparam logic [AW-1:0]      ExitWord   = CtrlWord + AW'(2);
  localparam logic [CntW-1:0]    NumImg     = CntW'(NumOfTest);
  localparam logic [ImgCycW-1:0] WdLast     = ImgCycW'(TimeoutCycles - 32'd1);
  // Accuracy compare is done in a width wide enough for correct*100 without wrap
  localparam int                 PW         = 2 * CntW + 7;
  localparam logic [PW-1:0]      PassThresh = PW'(AccThreshPct) * PW'(NumOfTest);

  // Bus decode: word-address match, only accepted write transfers count
  logic          xfer;
  logic [AW-1:0] word;
  logic          ctrl_hit;
  logic          img_hit;
  logic          exit_hit;
  logic          exit_ok;
  logic          unused_addr_lsbs;

  assign xfer             = dmem.req & dmem.write & dmem.ready;
  assign word             = dmem.addr[DWidth-1:2];
  assign ctrl_hit         = xfer && (word == CtrlWord);
  assign img_hit          = xfer && (word == ImgWord);
  assign exit_hit         = xfer && (word == ExitWord);
  assign exit_ok          = exit_hit && (dmem.wdata == ExitMagic);
  assign unused_addr_lsbs = ^dmem.addr[1:0];

  logic [1:0]         state_q,   state_d;
  logic [CntW-1:0]    img_q,     img_d;
  logic [CntW-1:0]    correct_q, correct_d;
  logic [63:0]        cycle_q,   cycle_d;
  logic [63:0]        instret_q, instret_d;
  logic [ImgCycW-1:0] timer_q,   timer_d;
  logic [ImgCycW-1:0] min_q,     min_d;
  logic [ImgCycW-1:0] max_q,     max_d;
  logic               ovf_q,     ovf_d;
  logic               pass_q,    pass_d;

  logic [ImgCycW-1:0] lat;
  logic               img_take;

  always_comb begin
    state_d   = state_q;
    img_d     = img_q;
    correct_d = correct_q;
    cycle_d   = cycle_q;
    instret_d = instret_q;
    timer_d   = timer_q;
    min_d     = min_q;
    max_d     = max_q;
    ovf_d     = ovf_q;
    lat       = (timer_q == '1) ? timer_q : timer_q + 1'b1;
    img_take  = 1'b0;

    if (ctrl_hit && dmem.wdata[1]) begin
      state_d   = StIdle;
      img_d     = '0;
      correct_d = '0;
      cycle_d   = '0;
      instret_d = '0;
      timer_d   = '0;
      min_d     = '1;
      max_d     = '0;
      ovf_d     = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (ctrl_hit && dmem.wdata[0]) begin
            state_d = StRun;
            timer_d = '0;
          end
        end
        StRun: begin
          cycle_d   = cycle_q + 64'd1;
          instret_d = instret_q + {63'd0, retire_i};
          if (timer_q != '1) timer_d = timer_q + 1'b1;
          if (img_hit) begin
            if (img_q < NumImg) begin
              img_take  = 1'b1;
              img_d     = img_q + 1'b1;
              correct_d = correct_q + {{(CntW-1){1'b0}}, dmem.wdata[0]};
              timer_d   = '0;
              if (lat < min_q) min_d = lat;
              if (lat > max_q) max_d = lat;
            end else begin
              ovf_d = 1'b1;
            end
          end
          // A counted image or valid exit in the expiry cycle beats the watchdog
          if (exit_ok) begin
            state_d = StDone;
          end else if (!img_take && (timer_q == WdLast)) begin
            state_d = StTimeout;
          end
        end
        default: begin
        end
      endcase
    end

    pass_d = (state_d == StDone) && ((PW'(correct_d) * PW'(100)) >= PassThresh);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      img_q     <= '0;
      correct_q <= '0;
      cycle_q   <= '0;
      instret_q <= '0;
      timer_q   <= '0;
      min_q     <= '1;
      max_q     <= '0;
      ovf_q     <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      img_q     <= img_d;
      correct_q <= correct_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
      timer_q   <= timer_d;
      min_q     <= min_d;
      max_q     <= max_d;
      ovf_q     <= ovf_d;
      pass_q    <= pass_d;
    end
  end

  assign state_o       = state_q;
  assign img_cnt_o     = img_q;
  assign correct_cnt_o = correct_q;
  assign cycle_cnt_o   = cycle_q;
  assign instret_cnt_o = instret_q;
  assign min_img_cyc_o = min_q;
  assign max_img_cyc_o = max_q;
  assign overflow_o    = ovf_q;
  assign pass_o        = pass_q;

endmodule

// File: tb/tb_infer_perf_monitor.sv
// Bench for infer_perf_monitor: scenario tasks drive snooped bus traffic, push expected
// results into exp_q, then pop and compare once the outputs have settled.
module tb_infer_perf_monitor;

  localparam logic [31:0] BASE  = 32'h0200_0000;
  localparam logic [31:0] CTRL  = BASE;
  localparam logic [31:0] IMG   = BASE + 32'd4;
  localparam logic [31:0] EXIT  = BASE + 32'd8;
  localparam logic [31:0] RSVD  = BASE + 32'd12;
  localparam logic [31:0] MAGIC = 32'd99999;
  localparam logic [227:0] RST_ALL = {2'd0, 16'd0, 16'd0, 64'd0, 64'd0,
                                      32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        retire = 1'b0;
  logic [1:0]  state_o;
  logic [15:0] img_cnt_o;
  logic [15:0] correct_cnt_o;
  logic [63:0] cycle_cnt_o;
  logic [63:0] instret_cnt_o;
  logic [31:0] min_img_cyc_o;
  logic [31:0] max_img_cyc_o;
  logic        overflow_o;
  logic        pass_o;
  logic [227:0] all_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp;

  infer_perf_monitor_if #(.DWidth(32)) bus ();

  infer_perf_monitor #(.TimeoutCycles(32'd50)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .dmem          (bus),
    .retire_i      (retire),
    .state_o       (state_o),
    .img_cnt_o     (img_cnt_o),
    .correct_cnt_o (correct_cnt_o),
    .cycle_cnt_o   (cycle_cnt_o),
    .instret_cnt_o (instret_cnt_o),
    .min_img_cyc_o (min_img_cyc_o),
    .max_img_cyc_o (max_img_cyc_o),
    .overflow_o    (overflow_o),
    .pass_o        (pass_o)
  );

  assign all_o = {state_o, img_cnt_o, correct_cnt_o, cycle_cnt_o, instret_cnt_o,
                  min_img_cyc_o, max_img_cyc_o, overflow_o, pass_o};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got sim_time=%0t exp finish_before_limit", $time);
    $fatal(1, "bench time limit");
  end

  // ---------------- driver tasks (enter and leave at 1ns after a posedge) ----------------
  task automatic bus_cycle(input logic req, input logic wr_en, input logic rdy,
                           input logic [31:0] a, input logic [31:0] d);
    bus.req = req; bus.write = wr_en; bus.ready = rdy; bus.addr = a; bus.wdata = d;
    @(posedge clk); #1;
    bus.req = 1'b0; bus.write = 1'b0; bus.ready = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_cycle(1'b1, 1'b1, 1'b1, a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++;
    if (all_o !== RST_ALL) begin errors++; $display("FAIL reset_in got %h exp %h", all_o, RST_ALL); end
    rst_n = 1'b1;
    idle(2);
    checks++;
    if (all_o !== RST_ALL) begin errors++; $display("FAIL reset_after got %h exp %h", all_o, RST_ALL); end
  endtask

  task automatic test_basic();
    exp_q.push_back(64'd2); exp_q.push_back(64'd3); exp_q.push_back(64'd2);
    exp_q.push_back(64'd10); exp_q.push_back(64'd15); exp_q.push_back(64'd46);
    exp_q.push_back(64'd0); exp_q.push_back(64'd46); exp_q.push_back(64'd3);
    wr(CTRL, 32'd1);
    checks++;
    if (state_o !== 2'd1) begin errors++; $display("FAIL t1_run got %0d exp 1", state_o); end
    idle(9);  wr(IMG, 32'd1);
    idle(14); wr(IMG, 32'd0);
    idle(14); wr(IMG, 32'd1);
    idle(5);  wr(EXIT, MAGIC);
    exp = exp_q.pop_front(); checks++;
    if (64'(state_o) !== exp) begin errors++; $display("FAIL t1_state got %0d exp %0d", state_o, exp); end
    exp = exp_q.pop_front(); checks++;
    if (64'(img_cnt_o) !== exp) begin errors++; $display("FAIL t1_img got %0d exp %0d", img_cnt_o, exp); end
    exp = exp_q.pop_front(); checks++;
    if (64'(correct_cnt_o) !== exp) begin errors++; $display("FAIL t1_correct got %0d exp %0d", correct_cnt_o, exp); end
    exp = exp_q.pop_front(); checks++;
    if (64'(min_img_cyc_o) !== exp) begin errors++; $display("FAIL t1_min got %0d exp %0d", min_img_cyc_o, exp); end
    exp = exp_q.pop_front(); checks++;
    if (64'(max_img_cyc_o) !== exp) begin errors++; $display("FAIL t1_max got %0d exp %0d", max_img_cyc_o, exp); end
    exp = exp_q.pop_front(); checks++;
    if (cycle_cnt_o !== exp) begin errors++; $display("FAIL t1_cycles got %0d exp %0d", cycle_cnt_o, exp); end
    exp = exp_q.pop_front(); checks++;
    if (64'(pass_o) !== exp) begin errors++; $display("FAIL t1_pass got %0d exp %0d", pass_o, exp); end
    idle(3);
    wr(IMG, 32'd1);
    exp = exp_q.pop_front(); checks++;
    if (cycle_cnt_o !== exp) begin errors++; $display("FAIL t1_frozen_cycles got %0d exp %0d", cycle_cnt_o, exp); end
    exp = exp_q.pop_front(); checks++;
    if (64'(img_cnt_o) !== exp) begin errors++; $display("FAIL t1_img_in_done got %0d exp %0d", img_cnt_o, exp); end
  endtask

  task automatic test_pass(input int n_correct, input logic exp_pass);
    int g;
    int lat_min;
    int lat_max;
    int cyc;
    logic d;
    lat_min = 1 << 30; lat_max = 0; cyc = 0;
    wr(CTRL, 32'd2);
    checks++;
    if (all_o !== RST_ALL) begin errors++; $display("FAIL t2_clear got %h exp %h", all_o, RST_ALL); end
    wr(CTRL, 32'd1);
    for (int i = 0; i < 100; i++) begin
      g = int'($urandom_range(0, 6));
      idle(g);
      d = (((i * 7) % 100) < n_correct);
      wr(IMG, ($urandom & 32'hFFFF_FFFE) | {31'd0, d});
      if (g + 1 < lat_min) lat_min = g + 1;
      if (g + 1 > lat_max) lat_max = g + 1;
      cyc += g + 1;
    end
    idle(2);
    wr(EXIT, MAGIC);
    cyc += 3;
    exp_q.push_back(64'd2); exp_q.push_back(64'd100); exp_q.push_back(64'(n_correct));
    exp_q.push_back(64'(lat_min)); exp_q.push_back(64'(lat_max)); exp_q.push_back(64'(cyc));
    exp_q.push_back(64'(exp_pass));
    exp = exp_q.pop_front(); checks++;
    if (64'(state_o) !== exp) begin errors++; $display("FAIL t2_state got %0d exp %0d", state_o, exp); end
    exp = exp_q.pop_front(); checks++;
    if (64'(img_cnt_o) !== exp) begin errors++; $display("FAIL t2_img got %0d exp %0d", img_cnt_o, exp); end
    exp = exp_q.pop_front(); checks++;
    if (64'(correct_cnt_o) !== exp) begin errors++; $display("FAIL t2_correct got %0d exp %0d", correct_cnt_o, exp); end
    exp = exp_q.pop_front(); checks++;
    if (64'(min_img_cyc_o) !== exp) begin errors++; $display("FAIL t2_min got %0d exp %0d", min_img_cyc_o, exp); end
    exp = exp_q.pop_front(); checks++;
    if (64'(max_img_cyc_o) !== exp) begin errors++; $display("FAIL t2_max got %0d exp %0d", max_img_cyc_o, exp); end
    exp = exp_q.pop_front(); checks++;
    if (cycle_cnt_o !== exp) begin errors++; $display("FAIL t2_cycles got %0d exp %0d", cycle_cnt_o, exp); end
    exp = exp_q.pop_front(); checks++;
    if (64'(pass_o) !== exp) begin errors++; $display("FAIL t2_pass got %0d exp %0d", pass_o, exp); end
  endtask

  task automatic test_timeout();
    wr(CTRL, 32'd2); wr(CTRL, 32'd1);
    idle(49);
    checks++;
    if (state_o !== 2'd1) begin errors++; $display("FAIL t3_run_at_49 got %0d exp 1", state_o); end
    idle(1);
    checks++;
    if (state_o !== 2'd3) begin errors++; $display("FAIL t3_timeout_at_50 got %0d exp 3", state_o); end
    checks++;
    if (cycle_cnt_o !== 64'd50) begin errors++; $display("FAIL t3_cycles got %0d exp 50", cycle_cnt_o); end
    idle(3);
    wr(CTRL, 32'd1);
    wr(IMG, 32'd1);
    checks++;
    if ({state_o, img_cnt_o} !== {2'd3, 16'd0}) begin
      errors++; $display("FAIL t3_sticky got st=%0d img=%0d exp st=3 img=0", state_o, img_cnt_o);
    end
    wr(CTRL, 32'd2); wr(CTRL, 32'd1);
    idle(49);
    wr(IMG, 32'd1);
    checks++;
    if ({state_o, img_cnt_o, min_img_cyc_o, max_img_cyc_o} !== {2'd1, 16'd1, 32'd50, 32'd50}) begin
      errors++;
      $display("FAIL t3_img_wins got st=%0d img=%0d min=%0d max=%0d exp st=1 img=1 min=50 max=50",
               state_o, img_cnt_o, min_img_cyc_o, max_img_cyc_o);
    end
    idle(49);
    checks++;
    if (state_o !== 2'd1) begin errors++; $display("FAIL t3_rerun_at_49 got %0d exp 1", state_o); end
    idle(1);
    checks++;
    if (state_o !== 2'd3) begin errors++; $display("FAIL t3_retimeout got %0d exp 3", state_o); end
    wr(CTRL, 32'd2); wr(CTRL, 32'd1);
    idle(49);
    wr(EXIT, MAGIC);
    checks++;
    if (state_o !== 2'd2) begin errors++; $display("FAIL t3_exit_wins got %0d exp 2", state_o); end
  endtask

  task automatic test_overflow();
    wr(CTRL, 32'd2); wr(CTRL, 32'd1);
    for (int i = 0; i < 100; i++) wr(IMG, 32'd1);
    checks++;
    if ({img_cnt_o, overflow_o} !== {16'd100, 1'b0}) begin
      errors++; $display("FAIL t4_at_limit got img=%0d ovf=%0d exp img=100 ovf=0", img_cnt_o, overflow_o);
    end
    wr(IMG, 32'd1);
    checks++;
    if ({state_o, img_cnt_o, correct_cnt_o, overflow_o} !== {2'd1, 16'd100, 16'd100, 1'b1}) begin
      errors++;
      $display("FAIL t4_overflow got st=%0d img=%0d cor=%0d ovf=%0d exp st=1 img=100 cor=100 ovf=1",
               state_o, img_cnt_o, correct_cnt_o, overflow_o);
    end
    wr(EXIT, 32'd12345);
    checks++;
    if (state_o !== 2'd1) begin errors++; $display("FAIL t4_bad_exit got %0d exp 1", state_o); end
    wr(EXIT, MAGIC);
    checks++;
    if ({state_o, overflow_o, pass_o} !== {2'd2, 1'b1, 1'b1}) begin
      errors++; $display("FAIL t4_done got st=%0d ovf=%0d pass=%0d exp st=2 ovf=1 pass=1", state_o, overflow_o, pass_o);
    end
    wr(CTRL, 32'd2);
    checks++;
    if (all_o !== RST_ALL) begin errors++; $display("FAIL t4_clear got %h exp %h", all_o, RST_ALL); end
  endtask

  task automatic test_ignore();
    wr(CTRL, 32'd2); wr(CTRL, 32'd1);
    for (int i = 0; i < 200; i++) begin
      retire = (i % 2 == 0);
      if (i % 40 == 39) wr(IMG, 32'd1);
      else begin
        case (i % 6)
          0: bus_cycle(1'b1, 1'b0, 1'b1, IMG, $urandom | 32'd1);
          1: bus_cycle(1'b1, 1'b1, 1'b0, IMG, 32'd1);
          2: bus_cycle(1'b1, 1'b1, 1'b1, BASE + 32'd16, $urandom);
          3: bus_cycle(1'b1, 1'b1, 1'b0, EXIT, MAGIC);
          4: bus_cycle(1'b0, 1'b1, 1'b1, CTRL, 32'd2);
          default: wr(RSVD, 32'd3);
        endcase
      end
    end
    retire = 1'b0;
    wr(EXIT, MAGIC);
    exp_q.push_back(64'd2); exp_q.push_back(64'd5); exp_q.push_back(64'd100);
    exp_q.push_back(64'd201); exp_q.push_back(64'd40);
    exp = exp_q.pop_front(); checks++;
    if (64'(state_o) !== exp) begin errors++; $display("FAIL t5_state got %0d exp %0d", state_o, exp); end
    exp = exp_q.pop_front(); checks++;
    if (64'(img_cnt_o) !== exp) begin errors++; $display("FAIL t5_img got %0d exp %0d", img_cnt_o, exp); end
    exp = exp_q.pop_front(); checks++;
    if (instret_cnt_o !== exp) begin errors++; $display("FAIL t5_instret got %0d exp %0d", instret_cnt_o, exp); end
    exp = exp_q.pop_front(); checks++;
    if (cycle_cnt_o !== exp) begin errors++; $display("FAIL t5_cycles got %0d exp %0d", cycle_cnt_o, exp); end
    exp = exp_q.pop_front(); checks++;
    if (64'(max_img_cyc_o) !== exp) begin errors++; $display("FAIL t5_max got %0d exp %0d", max_img_cyc_o, exp); end
  endtask

  task automatic test_back_to_back();
    wr(CTRL, 32'd2);
    wr(CTRL, 32'd3);
    checks++;
    if (state_o !== 2'd0) begin errors++; $display("FAIL b2b_clear_prio got %0d exp 0", state_o); end
    wr(IMG, 32'd1);
    checks++;
    if (img_cnt_o !== 16'd0) begin errors++; $display("FAIL b2b_img_in_idle got %0d exp 0", img_cnt_o); end
    wr(CTRL, 32'd1);
    wr(IMG, 32'd1); wr(IMG, 32'd1); wr(IMG, 32'd0);
    checks++;
    if ({img_cnt_o, correct_cnt_o, min_img_cyc_o, max_img_cyc_o} !== {16'd3, 16'd2, 32'd1, 32'd1}) begin
      errors++;
      $display("FAIL b2b_lat got img=%0d cor=%0d min=%0d max=%0d exp img=3 cor=2 min=1 max=1",
               img_cnt_o, correct_cnt_o, min_img_cyc_o, max_img_cyc_o);
    end
    wr(CTRL, 32'd2);
    checks++;
    if (all_o !== RST_ALL) begin errors++; $display("FAIL b2b_clear_run got %h exp %h", all_o, RST_ALL); end
  endtask

  task automatic test_async_reset();
    wr(CTRL, 32'd1);
    retire = 1'b1;
    idle(10);
    wr(IMG, 32'd1);
    idle(5);
    retire = 1'b0;
    checks++;
    if ({state_o, img_cnt_o, instret_cnt_o} !== {2'd1, 16'd1, 64'd16}) begin
      errors++; $display("FAIL t6_pre got st=%0d img=%0d ret=%0d exp st=1 img=1 ret=16", state_o, img_cnt_o, instret_cnt_o);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (all_o !== RST_ALL) begin errors++; $display("FAIL t6_async got %h exp %h", all_o, RST_ALL); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (all_o !== RST_ALL) begin errors++; $display("FAIL t6_after got %h exp %h", all_o, RST_ALL); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.req = 1'b0; bus.write = 1'b0; bus.ready = 1'b0; bus.addr = '0; bus.wdata = '0;
    #23;
    test_reset();
    test_basic();
    test_pass(90, 1'b1);
    test_pass(89, 1'b0);
    test_timeout();
    test_overflow();
    test_ignore();
    test_back_to_back();
    test_async_reset();
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
